// File: rtl/accel_avg_filter_if.sv
// accel_avg_filter_if: sample-in / average-out bundle; master drives i_* strobe, samples, clear; slave drives o_* averages and status
interface accel_avg_filter_if;
  logic       i_sample_valid;
  logic       i_clear;
  logic [7:0] i_x;
  logic [7:0] i_y;
  logic [7:0] i_z;
  logic [7:0] o_x_avg;
  logic [7:0] o_y_avg;
  logic [7:0] o_z_avg;
  logic       o_avg_valid;
  logic       o_primed;
  logic       o_tilt;
  logic       o_busy;
  logic       o_drop;
  modport master (
    output i_sample_valid, i_clear, i_x, i_y, i_z,
    input  o_x_avg, o_y_avg, o_z_avg, o_avg_valid, o_primed, o_tilt, o_busy, o_drop
  );
  modport slave (
    input  i_sample_valid, i_clear, i_x, i_y, i_z,
    output o_x_avg, o_y_avg, o_z_avg, o_avg_valid, o_primed, o_tilt, o_busy, o_drop
  );
endinterface

// File: rtl/accel_avg_filter.sv
// accel_avg_filter: per-axis moving average with one adder sequenced over X/Y/Z; ports i_clk, i_rst (sync high), bus (slave: samples/strobe/clear in, averages/valid/primed/tilt/busy/drop out)
module accel_avg_filter #(
  parameter int         LOG2_DEPTH  = 2,
  parameter logic [7:0] TILT_THRESH = 8'd64
) (
  input logic          i_clk,
  input logic          i_rst,
  accel_avg_filter_if.slave bus
);
  localparam int SW    = 8 + LOG2_DEPTH;
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  typedef enum logic [1:0] {S_IDLE, S_X, S_Y, S_Z} state_t;
  state_t                r_state, w_next;
  logic signed [7:0]     r_cap [3];
  logic signed [SW-1:0]  r_sum [3];
  logic signed [7:0]     r_buf [3][DEPTH];
  logic [LOG2_DEPTH:0]   r_fill, w_fill_nxt;
  logic [LOG2_DEPTH-1:0] r_ptr;
  logic [7:0]            r_x_avg, r_y_avg, r_z_avg;
  logic                  r_avg_valid, r_primed, r_tilt, r_drop;
  logic [1:0]            w_ax;
  logic                  w_full;
  logic signed [SW-1:0]  w_new, w_old, w_sum;
  logic signed [7:0]     w_xa, w_ya, w_za;
  function automatic logic signed [7:0] avg(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = s >>> LOG2_DEPTH;
    return t[7:0];
  endfunction
  function automatic logic big(input logic signed [7:0] a);
    logic signed [8:0] e;
    logic [8:0]        m;
    e = 9'(a);
    m = e[8] ? -e : e;
    return m >= {1'b0, TILT_THRESH};
  endfunction
  always_comb begin
    w_next     = bus.i_clear ? S_IDLE :
                 r_state == S_IDLE ? (bus.i_sample_valid ? S_X : S_IDLE) :
                 r_state == S_X ? S_Y :
                 r_state == S_Y ? S_Z : S_IDLE;
    w_ax       = r_state == S_Y ? 2'd1 : r_state == S_Z ? 2'd2 : 2'd0;
    w_full     = r_fill[LOG2_DEPTH];
    w_fill_nxt = w_full ? r_fill : r_fill + (LOG2_DEPTH+1)'(1);
    w_new      = SW'(r_cap[w_ax]);
    w_old      = w_full ? SW'(r_buf[w_ax][r_ptr]) : '0;
    w_sum      = r_sum[w_ax] + w_new - w_old;
    w_xa       = avg(r_sum[0]);
    w_ya       = avg(r_sum[1]);
    w_za       = avg(w_sum);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_fill      <= '0;
      r_ptr       <= '0;
      r_x_avg     <= '0;
      r_y_avg     <= '0;
      r_z_avg     <= '0;
      r_avg_valid <= 1'b0;
      r_primed    <= 1'b0;
      r_tilt      <= 1'b0;
      r_drop      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_sum[i] <= '0;
        r_cap[i] <= '0;
      end
    end else begin
      r_state     <= w_next;
      r_avg_valid <= 1'b0;
      r_drop      <= bus.i_sample_valid && r_state != S_IDLE && !bus.i_clear;
      if (bus.i_clear) begin
        r_fill   <= '0;
        r_ptr    <= '0;
        r_primed <= 1'b0;
        for (int i = 0; i < 3; i++) r_sum[i] <= '0;
      end else if (r_state == S_IDLE) begin
        if (bus.i_sample_valid) begin
          r_cap[0] <= bus.i_x;
          r_cap[1] <= bus.i_y;
          r_cap[2] <= bus.i_z;
        end
      end else begin
        r_sum[w_ax] <= w_sum;
        if (r_state == S_Z) begin
          r_x_avg     <= w_xa;
          r_y_avg     <= w_ya;
          r_z_avg     <= w_za;
          r_avg_valid <= 1'b1;
          r_tilt      <= big(w_xa) | big(w_ya) | big(w_za);
          r_ptr       <= r_ptr + LOG2_DEPTH'(1);
          r_fill      <= w_fill_nxt;
          r_primed    <= w_fill_nxt[LOG2_DEPTH];
        end
      end
    end
  end
  always_ff @(posedge i_clk)
    if (!i_rst && !bus.i_clear && r_state != S_IDLE) r_buf[w_ax][r_ptr] <= r_cap[w_ax];
  assign bus.o_x_avg     = r_x_avg;
  assign bus.o_y_avg     = r_y_avg;
  assign bus.o_z_avg     = r_z_avg;
  assign bus.o_avg_valid = r_avg_valid;
  assign bus.o_primed    = r_primed;
  assign bus.o_tilt      = r_tilt;
  assign bus.o_busy      = r_state != S_IDLE;
  assign bus.o_drop      = r_drop;
endmodule

// File: tb/tb_accel_avg_filter.sv
// tb_accel_avg_filter: directed vectors with hand-computed averages, flags and timing for accel_avg_filter
module tb_accel_avg_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  accel_avg_filter_if bus();
  accel_avg_filter #(.LOG2_DEPTH(2), .TILT_THRESH(8'd64)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_set(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    bus.i_sample_valid = 1'b1;
    bus.i_x = x;
    bus.i_y = y;
    bus.i_z = z;
    tick();
    bus.i_sample_valid = 1'b0;
    chk("busy_after_e0", 32'(bus.o_busy), 32'd1);
    tick();
    tick();
    chk("valid_early", 32'(bus.o_avg_valid), 32'd0);
    tick();
    chk("valid_e3", 32'(bus.o_avg_valid), 32'd1);
  endtask
  initial begin
    bus.i_sample_valid = 1'b0;
    bus.i_clear = 1'b0;
    bus.i_x = '0;
    bus.i_y = '0;
    bus.i_z = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_avgs", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h0);
    chk("rst_flags", {27'h0, bus.o_avg_valid, bus.o_primed, bus.o_tilt, bus.o_busy, bus.o_drop}, 32'h0);
    run_set(8'h40, 8'h20, 8'h00);
    chk("s1_avgs", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h00100800);
    chk("s1_primed", 32'(bus.o_primed), 32'd0);
    chk("s1_tilt", 32'(bus.o_tilt), 32'd0);
    run_set(8'h40, 8'h20, 8'h00);
    chk("s2_x", 32'(bus.o_x_avg), 32'h20);
    run_set(8'h40, 8'h20, 8'h00);
    chk("s3_x", 32'(bus.o_x_avg), 32'h30);
    chk("s3_primed", 32'(bus.o_primed), 32'd0);
    run_set(8'h40, 8'h20, 8'h00);
    chk("s4_avgs", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h00402000);
    chk("s4_primed", 32'(bus.o_primed), 32'd1);
    chk("s4_tilt", 32'(bus.o_tilt), 32'd1);
    tick();
    chk("valid_pulse", 32'(bus.o_avg_valid), 32'd0);
    chk("tilt_held", 32'(bus.o_tilt), 32'd1);
    run_set(8'h00, 8'h20, 8'h00);
    chk("wrap_x", 32'(bus.o_x_avg), 32'h30);
    chk("wrap_tilt", 32'(bus.o_tilt), 32'd0);
    for (int i = 0; i < 4; i++) run_set(8'h80, 8'h00, 8'h00);
    chk("neg_avgs", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h00800000);
    chk("neg_tilt", 32'(bus.o_tilt), 32'd1);
    run_set(8'hFF, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) run_set(8'h00, 8'h00, 8'h00);
    chk("floor_x", 32'(bus.o_x_avg), 32'hFF);
    chk("floor_tilt", 32'(bus.o_tilt), 32'd0);
    bus.i_sample_valid = 1'b1;
    bus.i_x = 8'h40;
    tick();
    bus.i_x = 8'h7F;
    tick();
    bus.i_sample_valid = 1'b0;
    chk("drop_pulse", 32'(bus.o_drop), 32'd1);
    chk("drop_busy", 32'(bus.o_busy), 32'd1);
    tick();
    chk("drop_once", 32'(bus.o_drop), 32'd0);
    tick();
    chk("drop_valid", 32'(bus.o_avg_valid), 32'd1);
    chk("drop_x", 32'(bus.o_x_avg), 32'h10);
    tick();
    chk("drop_single", {30'h0, bus.o_avg_valid, bus.o_busy}, 32'h0);
    bus.i_sample_valid = 1'b1;
    bus.i_x = 8'h40;
    bus.i_y = 8'h40;
    tick();
    bus.i_sample_valid = 1'b0;
    tick();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("clr_busy", 32'(bus.o_busy), 32'd0);
    chk("clr_primed", 32'(bus.o_primed), 32'd0);
    chk("clr_held", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h00100000);
    tick();
    chk("clr_novalid", 32'(bus.o_avg_valid), 32'd0);
    run_set(8'h40, 8'h40, 8'h00);
    chk("clr_next", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h00101000);
    chk("clr_next_primed", 32'(bus.o_primed), 32'd0);
    bus.i_sample_valid = 1'b1;
    tick();
    bus.i_sample_valid = 1'b0;
    bus.i_clear = 1'b1;
    bus.i_sample_valid = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    bus.i_sample_valid = 1'b0;
    chk("clr_strobe_nodrop", {30'h0, bus.o_drop, bus.o_busy}, 32'h0);
    bus.i_sample_valid = 1'b1;
    tick();
    bus.i_sample_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_avgs", {8'h0, bus.o_x_avg, bus.o_y_avg, bus.o_z_avg}, 32'h0);
    chk("midrst_flags", {27'h0, bus.o_avg_valid, bus.o_primed, bus.o_tilt, bus.o_busy, bus.o_drop}, 32'h0);
    repeat (3) tick();
    chk("midrst_novalid", 32'(bus.o_avg_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
